kfpga_config_loader: RTL and testbench

- Sequences the serial configuration chain of the kFPGA core: clears it, streams a bitstream into it, then optionally reads it back by recirculating the chain and checking a CRC.
- Sits between a word-oriented host (bus bridge or SPI front end) and the core's config_in/config_out/config_enable/config_nreset pins.
- Shifts at most one bit per clock, and only while data is available.

---
 rtl/kfpga_config_loader.sv | 167 ++++++++++++++++
 tb/tb_kfpga_config_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/kfpga_config_loader.sv
// Configuration chain sequencer for the kFPGA core: clear, stream a word-fed
// bitstream one bit per clock, then optionally recirculate and CRC-check it.
module kfpga_config_loader #(
   parameter int WORD_WIDTH   = 32,
   parameter int CHAIN_BITS   = 2048,
   parameter int CLEAR_CYCLES = 4,
   parameter int VERIFY       = 1
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  config_in,
   input  logic                  config_out_fb,
   output logic                  config_enable,
   output logic                  config_nreset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int BW = $clog2(CHAIN_BITS + 1);
   localparam int SW = $clog2(WORD_WIDTH + 1);
   localparam int CW = (BW > SW) ? BW : SW;
   localparam int KW = $clog2(CLEAR_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_VERIFY,
      ST_DONE
   } state_t;

   state_t                state, state_nxt;
   logic [KW-1:0]         clr_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [WORD_WIDTH-1:0] shifter;
   logic [SW-1:0]         sh_cnt;
   logic [15:0]           crc_load;
   logic [15:0]           crc_rb;
   logic [15:0]           crc_rb_nxt;
   logic                  last_in;
   logic                  error_q;
   logic                  shifting;
   logic                  accept;
   logic                  bit_last;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   always_comb begin
      shifting   = (state == ST_LOAD) && (sh_cnt != '0);
      // Ready only while chain bits remain beyond those already held in the shifter,
      // so the word carrying the final chain bit is the last one accepted.
      word_ready = (state == ST_LOAD) && (sh_cnt <= SW'(1)) && (CW'(bit_cnt) > CW'(sh_cnt));
      accept     = word_valid && word_ready;
      bit_last   = (bit_cnt == BW'(1));
      crc_rb_nxt = crc_step(crc_rb, config_out_fb);

      config_enable = shifting || (state == ST_VERIFY);
      if (shifting)
         config_in = shifter[0];
      else if (state == ST_VERIFY)
         config_in = config_out_fb;
      else
         config_in = last_in;
      config_nreset = (state != ST_CLEAR);
      busy          = (state == ST_CLEAR) || (state == ST_LOAD) || (state == ST_VERIFY);
      done          = (state == ST_DONE);
      error         = error_q;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start && !abort) state_nxt = ST_CLEAR;
         ST_CLEAR: begin
            if (abort)
               state_nxt = ST_IDLE;
            else if (clr_cnt == KW'(CLEAR_CYCLES - 1))
               state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            if (abort)
               state_nxt = ST_IDLE;
            else if (shifting && bit_last)
               state_nxt = (VERIFY != 0) ? ST_VERIFY : ST_DONE;
         end
         ST_VERIFY: begin
            if (abort)
               state_nxt = ST_IDLE;
            else if (bit_last)
               state_nxt = ST_DONE;
         end
         ST_DONE:   if (start) state_nxt = abort ? ST_IDLE : ST_CLEAR;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state    <= ST_IDLE;
         clr_cnt  <= '0;
         bit_cnt  <= '0;
         shifter  <= '0;
         sh_cnt   <= '0;
         crc_load <= '0;
         crc_rb   <= '0;
         last_in  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (config_enable)
            last_in <= config_in;

         case (state)
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + KW'(1);
               if (state_nxt == ST_LOAD) begin
                  bit_cnt  <= BW'(CHAIN_BITS);
                  crc_load <= 16'hFFFF;
                  sh_cnt   <= '0;
               end
            end
            ST_LOAD: begin
               if (shifting) begin
                  bit_cnt  <= bit_cnt - BW'(1);
                  crc_load <= crc_step(crc_load, shifter[0]);
               end
               if (accept) begin
                  shifter <= word_data;
                  sh_cnt  <= SW'(WORD_WIDTH);
               end else if (shifting) begin
                  shifter <= shifter >> 1;
                  sh_cnt  <= sh_cnt - SW'(1);
               end
               if (state_nxt == ST_VERIFY) begin
                  bit_cnt <= BW'(CHAIN_BITS);
                  crc_rb  <= 16'hFFFF;
               end
            end
            ST_VERIFY: begin
               bit_cnt <= bit_cnt - BW'(1);
               crc_rb  <= crc_rb_nxt;
               if (state_nxt == ST_DONE)
                  error_q <= (crc_rb_nxt != crc_load);
            end
            default: ;
         endcase

         if (state_nxt == ST_CLEAR && state != ST_CLEAR) begin
            clr_cnt <= '0;
            error_q <= 1'b0;
         end
         if (state_nxt == ST_IDLE || (state == ST_LOAD && state_nxt == ST_DONE))
            error_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kfpga_config_loader.sv
// Randomized bench: two loaders (64- and 40-bit chains) driving shift-register
// chain models; load, stall, fault, partial-word, abort and reset scenarios.
module tb_kfpga_config_loader;

   logic        clk = 1'b0;
   logic        nreset;
   logic        start[2], abort[2], wvalid[2], wready[2];
   logic        cin[2], cfb[2], cen[2], cnr[2], busy[2], done[2], error[2];
   logic [31:0] wdata[2];

   logic [63:0] chain[2], loaded[2];
   int          en_tot[2], ncl_tot[2], acc_tot[2], idle_tot[2], ensc[2];
   bit          s_en[2], s_in[2], s_nr[2];
   bit          fault_arm[2];
   int          fault_pos[2];
   int          n_checks = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   kfpga_config_loader #(.WORD_WIDTH(32), .CHAIN_BITS(64), .CLEAR_CYCLES(4), .VERIFY(1)) dut0 (
      .clock(clk), .nreset(nreset), .start(start[0]), .abort(abort[0]),
      .word_data(wdata[0]), .word_valid(wvalid[0]), .word_ready(wready[0]),
      .config_in(cin[0]), .config_out_fb(cfb[0]), .config_enable(cen[0]),
      .config_nreset(cnr[0]), .busy(busy[0]), .done(done[0]), .error(error[0]));

   kfpga_config_loader #(.WORD_WIDTH(32), .CHAIN_BITS(40), .CLEAR_CYCLES(4), .VERIFY(1)) dut1 (
      .clock(clk), .nreset(nreset), .start(start[1]), .abort(abort[1]),
      .word_data(wdata[1]), .word_valid(wvalid[1]), .word_ready(wready[1]),
      .config_in(cin[1]), .config_out_fb(cfb[1]), .config_enable(cen[1]),
      .config_nreset(cnr[1]), .busy(busy[1]), .done(done[1]), .error(error[1]));

   assign cfb[0] = chain[0][0];
   assign cfb[1] = chain[1][0];

   function automatic int cb(input int i);
      return (i == 0) ? 64 : 40;
   endfunction

   // Sample pin levels mid-cycle; the chain model applies them on the next rising edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         s_en[i]     <= (cen[i] === 1'b1);
         s_in[i]     <= (cin[i] === 1'b1);
         s_nr[i]     <= (cnr[i] !== 1'b0);
         en_tot[i]   <= en_tot[i] + ((cen[i] === 1'b1) ? 1 : 0);
         ncl_tot[i]  <= ncl_tot[i] + ((cnr[i] === 1'b0) ? 1 : 0);
         acc_tot[i]  <= acc_tot[i] + ((wvalid[i] === 1'b1 && wready[i] === 1'b1) ? 1 : 0);
         idle_tot[i] <= idle_tot[i] + ((busy[i] === 1'b1 && cnr[i] === 1'b1 && cen[i] === 1'b0) ? 1 : 0);
      end
   end

   always @(posedge clk) begin : chain_model
      logic [63:0] nxt;
      for (int i = 0; i < 2; i++) begin
         if (!s_nr[i]) begin
            chain[i] <= '0;
            ensc[i]  <= 0;
         end else if (s_en[i]) begin
            nxt = chain[i] >> 1;
            if (s_in[i]) nxt[cb(i)-1] = 1'b1;
            if (ensc[i] + 1 == cb(i)) begin
               loaded[i] <= nxt;
               if (fault_arm[i]) nxt[fault_pos[i]] = ~nxt[fault_pos[i]];
            end
            chain[i] <= nxt;
            ensc[i]  <= ensc[i] + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_quiet(input int i, input string tag);
      check($sformatf("%s busy", tag), 64'(busy[i]), 64'd0);
      check($sformatf("%s done", tag), 64'(done[i]), 64'd0);
      check($sformatf("%s error", tag), 64'(error[i]), 64'd0);
      check($sformatf("%s enable", tag), 64'(cen[i]), 64'd0);
      check($sformatf("%s nreset", tag), 64'(cnr[i]), 64'd1);
      check($sformatf("%s ready", tag), 64'(wready[i]), 64'd0);
   endtask

   task automatic run_load(input int i, input logic [31:0] w0, input logic [31:0] w1,
                           input int gap, input bit fault, input string tag);
      int b_en, b_ncl, b_acc, b_idle, idx, hold;
      bit got_done;
      logic [63:0] exp;
      exp = {w1, w0};
      if (cb(i) < 64) exp = exp & ((64'd1 << cb(i)) - 64'd1);
      b_en = en_tot[i]; b_ncl = ncl_tot[i]; b_acc = acc_tot[i]; b_idle = idle_tot[i];
      fault_arm[i] = fault;
      fault_pos[i] = $urandom_range(cb(i) - 1, 0);
      @(posedge clk); #1 start[i] = 1'b1;
      @(posedge clk); #1 start[i] = 1'b0;
      idx = 0; hold = 0; got_done = 1'b0;
      for (int c = 0; c < 1000 && !got_done; c++) begin
         wdata[i]  = (idx == 0) ? w0 : (idx == 1) ? w1 : $urandom;
         wvalid[i] = !(idx == 1 && hold < gap);
         @(negedge clk);
         if (done[i] === 1'b1) got_done = 1'b1;
         else begin
            if (wvalid[i] && wready[i]) idx++;
            else if (idx == 1 && wready[i] && !wvalid[i]) hold++;
            @(posedge clk); #1;
         end
      end
      wvalid[i] = 1'b0;
      check($sformatf("%s reached done", tag), 64'(got_done), 64'd1);
      @(posedge clk); #1;
      check($sformatf("%s error", tag), 64'(error[i]), 64'(fault));
      check($sformatf("%s loaded chain", tag), loaded[i], exp);
      check($sformatf("%s final chain", tag), chain[i],
            fault ? (exp ^ (64'd1 << fault_pos[i])) : exp);
      check($sformatf("%s enables", tag), 64'(en_tot[i] - b_en), 64'(2 * cb(i)));
      check($sformatf("%s clear cycles", tag), 64'(ncl_tot[i] - b_ncl), 64'd4);
      check($sformatf("%s words accepted", tag), 64'(acc_tot[i] - b_acc), 64'd2);
      check($sformatf("%s stall cycles", tag), 64'(idle_tot[i] - b_idle), 64'(1 + gap));
      check($sformatf("%s busy", tag), 64'(busy[i]), 64'd0);
      check($sformatf("%s done level", tag), 64'(done[i]), 64'd1);
      check($sformatf("%s enable", tag), 64'(cen[i]), 64'd0);
      check($sformatf("%s nreset", tag), 64'(cnr[i]), 64'd1);
   endtask

   // Start a load on instance 0 and return once n enables have been seen.
   task automatic partial_load(input int n, output logic [31:0] w, output int seen);
      bit ok;
      w = $urandom;
      seen = 0; ok = 1'b0;
      @(posedge clk); #1 start[0] = 1'b1; wdata[0] = w; wvalid[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         if (cen[0] === 1'b1) seen++;
         if (seen == n) ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      check("partial load reached", 64'(ok), 64'd1);
   endtask

   task automatic abort_test();
      logic [31:0] w;
      logic [63:0] exp;
      int n;
      partial_load(10, w, n);
      @(posedge clk); #1 abort[0] = 1'b1; start[0] = 1'b1;
      @(negedge clk);
      if (cen[0] === 1'b1) n++;
      @(posedge clk); #1 abort[0] = 1'b0; start[0] = 1'b0; wvalid[0] = 1'b0;
      check_quiet(0, "abort");
      exp = ((64'(w) & ((64'd1 << n) - 64'd1)) << (64 - n));
      repeat (5) @(posedge clk);
      #1;
      check("abort start ignored busy", 64'(busy[0]), 64'd0);
      check("abort chain kept", chain[0], exp);
      run_load(0, $urandom, $urandom, 0, 1'b0, "restart");
   endtask

   task automatic reset_test();
      logic [31:0] w;
      int n;
      partial_load(20, w, n);
      #2 nreset = 1'b0;
      #1;
      check_quiet(0, "midload reset");
      check("midload reset config_in", 64'(cin[0]), 64'd0);
      @(posedge clk); #1 nreset = 1'b1; wvalid[0] = 1'b0;
      @(posedge clk); #1;
      check("after reset busy", 64'(busy[0]), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      nreset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; abort[i] = 1'b0; wvalid[i] = 1'b0; wdata[i] = '0;
         fault_arm[i] = 1'b0; fault_pos[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      check_quiet(0, "reset0");
      check_quiet(1, "reset1");
      check("reset config_in", 64'(cin[0]), 64'd0);
      nreset = 1'b1;
      @(posedge clk); #1;

      run_load(0, 32'hDEADBEEF, 32'h01234567, 0, 1'b0, "b2b");
      run_load(0, $urandom, $urandom, 3, 1'b0, "stall");
      run_load(0, $urandom, $urandom, 0, 1'b1, "fault");
      run_load(1, $urandom, $urandom, 0, 1'b0, "partial");
      run_load(1, $urandom, $urandom, 2, 1'b1, "partial fault");
      abort_test();
      reset_test();
      for (int k = 0; k < 6; k++) begin
         int i;
         i = $urandom_range(1, 0);
         run_load(i, $urandom, $urandom, $urandom_range(5, 0), 1'($urandom_range(1, 0)),
                  $sformatf("rand%0d", k));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
